// File: rtl/idct8_recon_pkg.sv
// Shared widths, saturation limits and FSM state type for the 8-point IDCT
// reconstruction engine.
package idct_pkg;
    localparam int COEF_IN_W = 19;
    localparam int ROM_W     = 16;
    localparam int OUT_W     = 8;
    localparam int ACC_W     = 38;
    localparam int PROD_W    = COEF_IN_W + ROM_W;

    localparam int SAT_MAX = (1 << (OUT_W - 1)) - 1;
    localparam int SAT_MIN = -(1 << (OUT_W - 1));

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;
endpackage

// File: rtl/idct8_recon_if.sv
// Coefficient-block input and sample-stream output handshakes of idct8_recon.
interface idct8_recon_if;
    import idct_pkg::*;

    logic signed [COEF_IN_W-1:0] coef0, coef1, coef2, coef3;
    logic signed [COEF_IN_W-1:0] coef4, coef5, coef6, coef7;
    logic                        in_valid;
    logic                        in_ready;
    logic signed [OUT_W-1:0]     out_data;
    logic [2:0]                  out_idx;
    logic                        out_last;
    logic                        out_valid;
    logic                        out_ready;

    modport master (
        output coef0, coef1, coef2, coef3, coef4, coef5, coef6, coef7,
        output in_valid, out_ready,
        input  in_ready, out_data, out_idx, out_last, out_valid
    );

    modport slave (
        input  coef0, coef1, coef2, coef3, coef4, coef5, coef6, coef7,
        input  in_valid, out_ready,
        output in_ready, out_data, out_idx, out_last, out_valid
    );
endinterface

// File: rtl/idct8_recon_coef_rom.sv
// Combinational 64-entry Q1.14 cosine ROM, address {n,k}:
// C[n][k] = round(16384 * s_k * cos((2n+1)k*pi/16)).
module idct_coef_rom
    import idct_pkg::*;
(
    input  logic [5:0]              addr,
    output logic signed [ROM_W-1:0] data
);
    logic [2:0]              n;
    logic [2:0]              k;
    logic [6:0]              phase;
    logic [5:0]              m;
    logic [3:0]              idx;
    logic                    neg;
    logic signed [ROM_W-1:0] mag;

    always_comb begin
        n     = addr[5:3];
        k     = addr[2:0];
        phase = {3'b000, n, 1'b1} * {4'b0000, k};
        // m is the angle in units of pi/16 modulo 2*pi; fold it onto the first quadrant
        m     = {1'b0, phase[4:0]};
        idx   = '0;
        neg   = 1'b0;
        if (m <= 6'd8) begin
            idx = m[3:0];
        end else if (m <= 6'd16) begin
            idx = 4'(6'd16 - m);
            neg = 1'b1;
        end else if (m <= 6'd24) begin
            idx = 4'(m - 6'd16);
            neg = 1'b1;
        end else begin
            idx = 4'(6'd32 - m);
        end

        case (idx)
            4'd0:    mag = 16'sd8192;
            4'd1:    mag = 16'sd8035;
            4'd2:    mag = 16'sd7568;
            4'd3:    mag = 16'sd6811;
            4'd4:    mag = 16'sd5793;
            4'd5:    mag = 16'sd4551;
            4'd6:    mag = 16'sd3135;
            4'd7:    mag = 16'sd1598;
            default: mag = 16'sd0;
        endcase

        if (k == 3'd0) begin
            data = 16'sd5793;
        end else begin
            data = neg ? -mag : mag;
        end
    end
endmodule

// File: rtl/idct8_recon.sv
// 8-point IDCT reconstruction: latches one coefficient block, rebuilds each
// sample with a serial MAC over the cosine ROM, and streams samples out.
module idct8_recon
    import idct_pkg::*;
#(
    parameter int SHIFT = 14
) (
    input logic          clk,
    input logic          rst_n,
    input logic          en,
    idct8_recon_if.slave bus
);
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(SAT_MAX);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(SAT_MIN);

    state_t                      state;
    logic [2:0]                  n;
    logic [2:0]                  k;
    logic signed [ACC_W-1:0]     acc;
    logic signed [ACC_W-1:0]     acc_next;
    logic signed [PROD_W-1:0]    prod;
    logic signed [ROM_W-1:0]     rom_data;
    logic signed [COEF_IN_W-1:0] blk [8];
    logic signed [OUT_W-1:0]     out_data;
    logic [2:0]                  out_idx;
    logic                        out_last;
    logic                        out_valid;
    logic                        accept;

    function automatic logic signed [ACC_W-1:0] round_shift(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] half;
        half = '0;
        half[SHIFT-1] = 1'b1;
        return (v + half) >>> SHIFT;
    endfunction

    function automatic logic signed [OUT_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
        if (v > SAT_HI) begin
            return OUT_W'(SAT_MAX);
        end else if (v < SAT_LO) begin
            return OUT_W'(SAT_MIN);
        end else begin
            return OUT_W'(v);
        end
    endfunction

    idct_coef_rom u_rom (
        .addr ({n, k}),
        .data (rom_data)
    );

    assign prod     = rom_data * blk[k];
    assign acc_next = acc + ACC_W'(prod);
    assign accept   = rst_n && en && (state == IDLE) && bus.in_valid;

    // Block register only loads in IDLE, so mid-block in_valid cannot disturb it
    always_ff @(posedge clk) begin
        if (accept) begin
            blk[0] <= bus.coef0;
            blk[1] <= bus.coef1;
            blk[2] <= bus.coef2;
            blk[3] <= bus.coef3;
            blk[4] <= bus.coef4;
            blk[5] <= bus.coef5;
            blk[6] <= bus.coef6;
            blk[7] <= bus.coef7;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            n         <= '0;
            k         <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        n     <= '0;
                        k     <= '0;
                        acc   <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    k   <= k + 3'd1;
                    if (k == 3'd7) begin
                        out_data  <= saturate(round_shift(acc_next));
                        out_idx   <= n;
                        out_last  <= (n == 3'd7);
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid <= 1'b0;
                        if (n == 3'd7) begin
                            state <= IDLE;
                        end else begin
                            n     <= n + 3'd1;
                            k     <= '0;
                            acc   <= '0;
                            state <= MAC;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_data  = out_data;
    assign bus.out_idx   = out_idx;
    assign bus.out_last  = out_last;
    assign bus.out_valid = out_valid;
endmodule

// File: doc/idct8_recon.md
# idct8_recon

Inverse 8-point DCT reconstruction engine for the EEG decompression path. It accepts one block of eight signed DCT coefficients (z0..z7, as produced by the per-coefficient encoder slices) over a valid/ready handshake. It rebuilds the eight 8-bit signed EEG samples with a single serial multiply-accumulate and a coefficient ROM, then streams the samples out one per handshake, with backpressure.

## Interface
- COEF_IN_W, 19 — width of each input DCT coefficient (signed)
- ROM_W, 16 — width of ROM cosine constants (signed, Q1.14)
- SHIFT, 14 — right-shift applied to the accumulated sum; integration sets it to match encoder gain
- OUT_W, 8 — reconstructed sample width (signed)
- clk  in  1  — single clock, rising edge
- rst_n  in  1  — reset, synchronous, active-low
- en  in  1  — clock enable; 0 freezes all state and blocks both handshakes
- coef0..coef7  in  COEF_IN_W each  — DCT coefficients X[0]..X[7], signed
- in_valid  in  1  — coefficient block valid
- in_ready  out  1  — block can be accepted
- out_data  out  OUT_W  — reconstructed sample x[n], signed
- out_idx  out  3  — sample index n
- out_last  out  1  — high when out_idx = 7
- out_valid  out  1  — out_data/out_idx/out_last valid
- out_ready  in  1  — downstream accepts sample

## Operation
- Math: x[n] = sat(round(Σ_{k=0..7} C[n][k]·X[k] / 2^SHIFT)).
  - C[n][k] = round(16384·s_k·cos((2n+1)kπ/16)), with s_0 = 1/(2√2) and s_k = 1/2 otherwise.
  - Example values: C[n][0] = 5793; C[0..7][1] = 8035, 6811, 4551, 1598, −1598, −4551, −6811, −8035.
- Widths:
  - Product is 35 bits signed.
  - Accumulator is 38 bits signed; it never overflows.
  - Round half-up: add 2^(SHIFT−1), then arithmetic shift right.
  - Saturate to [−128, 127].
- FSM states and transitions (only on edges with en=1):
  - IDLE: in_ready=1. On in_valid&&in_ready, latch coef0..7 into the block register, set n=0, k=0, acc=0, go to MAC.
  - MAC: each edge computes acc ← acc + C[n][k]·X[k] and k ← k+1. On the edge with k=7, register out_data = sat(round(acc + C[n][7]·X[7])), out_idx=n, out_last=(n==7), out_valid=1, and go to OUT.
  - OUT: hold all outputs stable until out_ready=1.
    - On handshake with n<7: clear out_valid, n ← n+1, k=0, acc=0, go to MAC.
    - On handshake with n=7: clear out_valid, go to IDLE.
- Boundary rules:
  - in_valid outside IDLE is ignored; the latched coefficients are never overwritten mid-block.
  - en=0 in any state holds every register, and no transfer completes regardless of in_valid or out_ready.
  - Reset mid-block discards the block: no partial samples are emitted afterwards.
- Reset values:
  - State=IDLE; n, k, acc = 0.
  - out_valid=0, out_data=0, out_idx=0, out_last=0.
  - in_ready=1 once state=IDLE (in_ready is decoded from state). Any input during rst_n=0 is ignored.

## Timing
- Take the accepting edge as E0, with en=1 and out_ready=1 throughout.
- Sample n: out_valid rises after edge E(8+9n) and handshakes at E(9+9n).
- Last handshake is at E72. in_ready rises after E72, so the next block is accepted at E73 at the earliest.
- Minimum block period is 73 cycles.
- Each cycle with out_ready=0 in OUT adds one cycle. Each cycle with en=0 adds one cycle.
- ROM read is combinational and settles within the MAC cycle.

## Structure
- Package idct_pkg holds:
  - width constants COEF_IN_W, ROM_W, OUT_W, ACC_W=38;
  - the state enum {IDLE, MAC, OUT};
  - the saturation limits.
- One sub-module, idct_coef_rom: combinational, 64 entries, address {n,k} (6 bits), data ROM_W bits signed.
- Top level contains the FSM, block register, MAC, and round/saturate logic.

## Test plan
- All coefficients 0 → eight samples of 0, out_idx 0..7, out_last only on idx 7.
- coef0=200, others 0 → all eight samples = 71 (5793·200/16384 = 70.7).
- coef0=−1000, others 0 → all eight samples = −128 (saturation); coef0=1131 → all = 127.
- coef1=256, others 0 → samples 126, 106, 71, 25, −25, −71, −106, −126.
- Hold out_ready=0 for 5 cycles while sample 3 is presented, and toggle in_valid with new data meanwhile:
  - out_data/out_idx stay stable;
  - in_ready stays 0;
  - the block completes with the original values;
  - period = 78 cycles.
- Reset and enable:
  - Assert rst_n=0 for one edge while sample 4 is pending → out_valid=0 and in_ready=1 next cycle; the next block reconstructs correctly.
  - en=0 for 3 cycles mid-MAC → outputs identical, shifted by 3 cycles.
